gate_tester: RTL and testbench

- Multi-channel, mode-selectable stimulus/compare engine for characterising external logic gates.
- Drives pseudo-random A/B vectors onto N_CH gate instances and waits a parametrised settle time.
- Samples each gate's output, compares it against the golden function of the selected mode, and keeps saturating per-channel error counts over a packet of PKG_LEN vectors.
- Sits beside the existing single-gate test blocks and is controlled by the same START/FINISH handshake.

---
 rtl/gate_tester_pkg.sv | 36 +++
 rtl/gt_lfsr16.sv | 22 ++
 rtl/gate_tester.sv | 123 ++++++++++++
 tb/tb_gate_tester.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_tester_pkg.sv
// Shared definitions for the gate tester: FSM encoding, gate mode codes,
// LFSR constants and the golden gate function.
package gate_tester_pkg;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_SEND = 5'b00010,
        ST_WAIT = 5'b00100,
        ST_CMP  = 5'b01000,
        ST_END  = 5'b10000
    } state_t;

    localparam logic [2:0] MODE_NOT  = 3'd0;
    localparam logic [2:0] MODE_BUF  = 3'd1;
    localparam logic [2:0] MODE_AND  = 3'd2;
    localparam logic [2:0] MODE_OR   = 3'd3;
    localparam logic [2:0] MODE_XOR  = 3'd4;
    localparam logic [2:0] MODE_NAND = 3'd5;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Reserved codes 6 and 7 fall through to XOR.
    function automatic logic gold_fn(input logic [2:0] mode, input logic a, input logic b);
        case (mode)
            MODE_NOT:  return ~a;
            MODE_BUF:  return a;
            MODE_AND:  return a & b;
            MODE_OR:   return a | b;
            MODE_NAND: return ~(a & b);
            default:   return a ^ b;
        endcase
    endfunction

endpackage

// File: rtl/gt_lfsr16.sv
// 16-bit Fibonacci LFSR shifting toward the MSB, with seed load and advance.
module gt_lfsr16
    import gate_tester_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] lfsr_next
);

    logic [15:0] lfsr_q;

    assign lfsr_next = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)   lfsr_q <= LFSR_SEED;
        else if (load)    lfsr_q <= LFSR_SEED;
        else if (advance) lfsr_q <= lfsr_next;
    end

endmodule

// File: rtl/gate_tester.sv
// Multi-channel stimulus/compare engine: drives LFSR vectors onto N_CH gates,
// waits WAIT_CYC cycles, compares against the golden function, counts errors.
module gate_tester
    import gate_tester_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int WAIT_CYC = 2,
    parameter int PKG_LEN  = 65535,
    parameter int ERR_W    = 32
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  GT_START,
    input  logic                  GT_ABORT,
    input  logic [2:0]            GT_MODE,
    output logic [N_CH-1:0]       GT_A,
    output logic [N_CH-1:0]       GT_B,
    input  logic [N_CH-1:0]       GT_IN,
    output logic                  GT_BUSY,
    output logic                  GT_FINISH,
    output logic [N_CH*ERR_W-1:0] GT_ERROR
);

    localparam logic [15:0] VEC_LAST  = 16'(PKG_LEN - 1);
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYC - 1);

    state_t      state_q, state_d;
    logic [2:0]  mode_q;
    logic [15:0] vec_cnt;
    logic [3:0]  wait_cnt;
    logic [15:0] lfsr_next;
    logic        start_run, send_en, cmp_en;
    logic        lfsr_unused;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (GT_START) state_d = ST_SEND;
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: if (wait_cnt == WAIT_LAST) state_d = ST_CMP;
            ST_CMP:  state_d = (vec_cnt == VEC_LAST) ? ST_END : ST_SEND;
            ST_END:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (GT_ABORT && state_q != ST_IDLE) state_d = ST_IDLE;
    end

    // Abort suppresses the SEND/CMP side effects of the cycle it lands in.
    always_comb begin
        start_run = 1'b0;
        send_en   = 1'b0;
        cmp_en    = 1'b0;
        case (state_q)
            ST_IDLE: start_run = GT_START;
            ST_SEND: send_en   = !GT_ABORT;
            ST_CMP:  cmp_en    = !GT_ABORT;
            default: ;
        endcase
    end

    assign GT_BUSY   = (state_q != ST_IDLE);
    assign GT_FINISH = (state_q == ST_END);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q   <= MODE_NOT;
            vec_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            if (start_run) begin
                mode_q  <= GT_MODE;
                vec_cnt <= '0;
            end else if (cmp_en) begin
                vec_cnt <= vec_cnt + 16'd1;
            end
            if (state_q == ST_SEND)      wait_cnt <= '0;
            else if (state_q == ST_WAIT) wait_cnt <= wait_cnt + 4'd1;
        end
    end

    gt_lfsr16 u_lfsr (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (start_run),
        .advance   (send_en),
        .lfsr_next (lfsr_next)
    );

    // Middle LFSR bits feed no channel for small N_CH.
    assign lfsr_unused = ^lfsr_next;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             a_q, b_q, mis;
        logic [ERR_W-1:0] err_q;

        assign mis = (GT_IN[i] != gold_fn(mode_q, a_q, b_q));

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                a_q   <= 1'b0;
                b_q   <= 1'b0;
                err_q <= '0;
            end else begin
                if (send_en) begin
                    a_q <= lfsr_next[i];
                    b_q <= lfsr_next[15-i];
                end
                if (start_run)                           err_q <= '0;
                else if (cmp_en && mis && err_q != '1)   err_q <= err_q + 1'b1;
            end
        end

        assign GT_A[i] = a_q;
        assign GT_B[i] = b_q;
        assign GT_ERROR[i*ERR_W +: ERR_W] = err_q;
    end

endmodule

// File: tb/tb_gate_tester.sv
// Scoreboard bench for gate_tester: stimulus pushes expected run results,
// a monitor pops and compares them whenever GT_FINISH pulses.
module tb_gate_tester;

    localparam int N_CH = 4, WAIT_CYC = 2, PKG_LEN = 16, ERR_W = 32;
    localparam int PKG2 = 40, ERR_W2 = 4;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic                  gt_start = 1'b0, gt_abort = 1'b0;
    logic [2:0]            gt_mode = 3'd0;
    logic [N_CH-1:0]       gt_a, gt_b, gt_in;
    logic                  gt_busy, gt_finish;
    logic [N_CH*ERR_W-1:0] gt_error;

    logic                   gt_start2 = 1'b0;
    logic [N_CH-1:0]        gt_a2, gt_b2, gt_in2;
    logic                   gt_busy2, gt_finish2;
    logic [N_CH*ERR_W2-1:0] gt_error2;

    // External gate model: ideal gate of model_mode, optional stuck-at-0 lanes, optional inversion.
    logic [2:0]      model_mode = 3'd2;
    logic [N_CH-1:0] model_stk  = '0;
    logic            model_inv  = 1'b0;

    function automatic logic ref_gate(input logic [2:0] m, input logic a, input logic b);
        case (m)
            3'd0: return !a;
            3'd1: return a;
            3'd2: return a && b;
            3'd3: return a || b;
            3'd5: return !(a && b);
            default: return a != b;
        endcase
    endfunction

    always_comb begin
        gt_in = '0;
        for (int i = 0; i < N_CH; i++)
            gt_in[i] = model_inv ^ (model_stk[i] ? 1'b0 : ref_gate(model_mode, gt_a[i], gt_b[i]));
    end
    assign gt_in2 = ~(gt_a2 & gt_b2);

    gate_tester #(.N_CH(N_CH), .WAIT_CYC(WAIT_CYC), .PKG_LEN(PKG_LEN), .ERR_W(ERR_W)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .GT_START(gt_start), .GT_ABORT(gt_abort),
        .GT_MODE(gt_mode), .GT_A(gt_a), .GT_B(gt_b), .GT_IN(gt_in), .GT_BUSY(gt_busy),
        .GT_FINISH(gt_finish), .GT_ERROR(gt_error));

    gate_tester #(.N_CH(N_CH), .WAIT_CYC(WAIT_CYC), .PKG_LEN(PKG2), .ERR_W(ERR_W2)) dut_sat (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .GT_START(gt_start2), .GT_ABORT(1'b0),
        .GT_MODE(3'd2), .GT_A(gt_a2), .GT_B(gt_b2), .GT_IN(gt_in2), .GT_BUSY(gt_busy2),
        .GT_FINISH(gt_finish2), .GT_ERROR(gt_error2));

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_vec = 0, n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct { int rel; logic [127:0] err; } exp_t;
    exp_t sb[$];
    exp_t sb2[$];
    exp_t mon_e;
    int start_cyc = 0, start2_cyc = 0;

    always @(negedge sys_clk) begin
        if (gt_finish) begin
            if (sb.size() == 0) check("unexpected_finish", 1, 0);
            else begin
                mon_e = sb.pop_front();
                check("finish_cycle", 128'(cyc - start_cyc), 128'(mon_e.rel));
                check("err_counts", gt_error, mon_e.err);
            end
        end
        if (gt_finish2) begin
            if (sb2.size() == 0) check("unexpected_finish_sat", 1, 0);
            else begin
                mon_e = sb2.pop_front();
                check("finish_cycle_sat", 128'(cyc - start2_cyc), 128'(mon_e.rel));
                check("err_counts_sat", 128'(gt_error2), mon_e.err);
            end
        end
    end

    function automatic logic [15:0] lfsr_after(input int n);
        logic [15:0] s;
        s = 16'hACE1;
        for (int k = 0; k < n; k++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        return s;
    endfunction

    // Expected per-lane counts for tester mode tm against a model of mode mm/stuck/invert.
    function automatic logic [127:0] exp_err(input logic [2:0] tm, input logic [2:0] mm,
                                             input logic [3:0] stk, input logic inv, input int nvec);
        logic [127:0] r;
        logic [15:0]  s;
        logic         o;
        int           cnt;
        r = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt = 0;
            for (int v = 1; v <= nvec; v++) begin
                s = lfsr_after(v);
                o = inv ^ (stk[i] ? 1'b0 : ref_gate(mm, s[i], s[15-i]));
                if (o != ref_gate(tm, s[i], s[15-i])) cnt++;
            end
            r[i*ERR_W +: ERR_W] = 32'(cnt);
        end
        return r;
    endfunction

    task automatic pulse_start(input logic [2:0] m);
        gt_mode = m;
        gt_start = 1'b1;
        start_cyc = cyc;
        @(negedge sys_clk);
        gt_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((gt_busy || gt_busy2) && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check(name, 128'({gt_busy, gt_busy2}), 0);
    endtask

    exp_t e;

    initial begin
        repeat (2) @(negedge sys_clk);
        check("rst_busy", gt_busy, 0);
        check("rst_finish", gt_finish, 0);
        check("rst_ab", {gt_a, gt_b}, 0);
        check("rst_error", gt_error, 0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // 1: ideal AND gate, timing and first vector
        model_mode = 3'd2; model_stk = '0; model_inv = 1'b0;
        e.rel = 65; e.err = '0; sb.push_back(e);
        pulse_start(3'd2);
        check("busy_cycle1", gt_busy, 1);
        @(negedge sys_clk);
        check("first_a", gt_a, 4'h3);
        check("first_b", gt_b, 4'hA);
        wait_idle("t1_timeout", 200);
        check("finish_one_cycle", gt_finish, 0);

        // 2: NOT mode, lane 2 stuck-at-0
        model_mode = 3'd0; model_stk = 4'b0100;
        e.rel = 65; e.err = exp_err(3'd0, 3'd0, 4'b0100, 1'b0, 16); sb.push_back(e);
        pulse_start(3'd0);
        wait_idle("t2_timeout", 200);

        // 3: tester OR vs XOR gate; GT_MODE changed mid-run must not matter
        model_mode = 3'd4; model_stk = '0;
        e.rel = 65; e.err = exp_err(3'd3, 3'd4, 4'b0000, 1'b0, 16); sb.push_back(e);
        pulse_start(3'd3);
        repeat (5) @(negedge sys_clk);
        gt_mode = 3'd0;
        wait_idle("t3_timeout", 200);

        // 4: 4-bit counters saturate at F with an inverted gate, 40 vectors
        e.rel = 161; e.err = 128'h0000_FFFF; sb2.push_back(e);
        gt_start2 = 1'b1; start2_cyc = cyc;
        @(negedge sys_clk);
        gt_start2 = 1'b0;
        wait_idle("t4_timeout", 400);

        // 5: abort during the 5th vector's WAIT
        model_mode = 3'd0; model_stk = 4'b0100;
        pulse_start(3'd0);
        repeat (17) @(negedge sys_clk);
        gt_abort = 1'b1;
        @(negedge sys_clk);
        gt_abort = 1'b0;
        check("abort_idle", gt_busy, 0);
        check("abort_counts", gt_error, exp_err(3'd0, 3'd0, 4'b0100, 1'b0, 4));
        check("abort_a_held", gt_a, 128'(lfsr_after(5) & 16'h000F));
        repeat (10) @(negedge sys_clk);
        check("abort_stays_idle", gt_busy, 0);
        model_stk = 4'b0000;
        e.rel = 65; e.err = '0; sb.push_back(e);
        pulse_start(3'd0);
        check("restart_clears", gt_error, 0);
        wait_idle("t5_timeout", 200);

        // 6: START held through a run, then async reset mid-run
        model_mode = 3'd4;
        e.rel = 65; e.err = exp_err(3'd3, 3'd4, 4'b0000, 1'b0, 16); sb.push_back(e);
        gt_mode = 3'd3; gt_start = 1'b1; start_cyc = cyc;
        repeat (80) @(negedge sys_clk);
        check("held_start_rerun", gt_busy, 1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst_busy", gt_busy, 0);
        check("async_rst_ab", {gt_a, gt_b}, 0);
        check("async_rst_error", gt_error, 0);
        gt_start = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("idle_after_rst", gt_busy, 0);

        check("sb_drained", 128'(sb.size() + sb2.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
